hack_screen_reader: RTL and testbench
=====================================

Name: hack_screen_reader

Overview:
Read-side counterpart to the 16-bit register/RAM path that the CPU writes. The block scans Hack screen memory word by word, loads each 16-bit word into an internal shift register, and serialises it as a pixel stream with a valid/ready handshake. It sits between screen RAM (registered read, 1-cycle latency) and the display/pixel sink.

Parameters:
WORDS_PER_ROW, 32, 16-bit words per scanline (512 px)
ROWS, 256, scanlines per frame
ADDR_W, 13, screen RAM address width; WORDS_PER_ROW*ROWS must be at most 2^ADDR_W

Ports:
CLK  input  1  clock, all state updates on posedge
RST_N  input  1  synchronous active-low reset, sampled on posedge CLK
start  input  1  begin one frame scan; sampled only in IDLE
mem_addr  output  ADDR_W  screen RAM word address
mem_rd  output  1  read strobe; mem_data valid in the following cycle
mem_data  input  16  RAM read data
pix  output  1  current pixel (1 = black)
pix_valid  output  1  pix is valid
pix_ready  input  1  sink accepts pix this cycle
line_end  output  1  qualifies the last pixel of a scanline
frame_end  output  1  qualifies the last pixel of the frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST_N=0 at posedge): state=IDLE; mem_addr=0, mem_rd=0, pix=0, pix_valid=0, line_end=0, frame_end=0, busy=0; shift register=0, bit count=0. Reset mid-frame aborts the scan immediately. No partial pixels are emitted afterwards.
- States: IDLE, FETCH, LOAD, SHIFT.
- IDLE: if start=1 -> FETCH, word address=0.
- FETCH, 1 cycle: mem_rd=1, mem_addr=word address -> LOAD.
- LOAD, 1 cycle: mem_rd=0; captures mem_data into the shift register at the posedge ending LOAD; bit count=0 -> SHIFT.
- SHIFT: pix_valid=1 and pix=shreg[0], so LSB is the leftmost pixel.
  - On a transfer (pix_valid & pix_ready): shift right by 1 and increment bit count.
  - While pix_ready=0: pix, pix_valid, line_end and frame_end hold stable.
  - After the transfer of bit 15:
    - if word address = WORDS_PER_ROW*ROWS-1 -> IDLE, word address=0;
    - else word address+1 -> FETCH.
- Latency: start sampled at edge k -> FETCH in cycle k+1, LOAD in k+2, first pix_valid in cycle k+3.
- Without the optional feature, each word costs 2 bubble cycles (FETCH, LOAD).
- line_end=1 during SHIFT when bit count=15 and (word address mod WORDS_PER_ROW)=WORDS_PER_ROW-1.
- frame_end=1 during SHIFT when bit count=15 and word address=WORDS_PER_ROW*ROWS-1. line_end is also 1 on this pixel.
- busy=0 only in IDLE. start is ignored while busy=1. start and a final transfer in the same cycle does not restart the scan; a new start is needed in IDLE.
- Address arithmetic is unsigned with no wrap mid-frame; the terminal word index is compared exactly.
- mem_data is sampled only in the capture cycle; its value is don't-care at all other times.

Optional Feature:
Macro SCREEN_READER_PREFETCH_EN.
- Defined: a second 16-bit holding register is added.
  - During SHIFT with bit count=0 of the current word, if a next word exists: issue mem_rd for word address+1, and capture it into the holding register the following cycle.
  - After the transfer of bit 15, the holding register is copied into the shift register and SHIFT continues with no bubble. Steady state is 1 pixel/cycle when pix_ready=1.
  - The first word of a frame still goes through FETCH and LOAD.
  - No prefetch is issued after the final word.
  - Reset clears the holding register and any pending prefetch.
- Undefined: no holding register; behaviour is exactly as in Behaviour.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with start=1 -> all outputs 0, busy=0; release -> still IDLE until start is sampled at RST_N=1.
- Word 0 = 16'h0001, pix_ready=1 -> mem_rd at cycle k+1 with addr 0; pix stream 1,0,0,…0 (16 px) from cycle k+3; then mem_rd with addr 1.
- Word 31 = 16'h8000 -> line_end=1 together with pix=1 only on the 512th pixel of row 0; the pixel holds while pix_ready is toggled 0/1.
- Full frame, all words 16'hFFFF -> exactly 131072 transfers of pix=1; 256 line_end pulses; 1 frame_end on the last transfer; busy falls 1 cycle later; final mem_addr 8191.
- Abort: RST_N=0 mid-row 10 -> next cycle pix_valid=0, busy=0; a new start rescans from addr 0.
- SCREEN_READER_PREFETCH_EN with pix_ready=1 -> frame completes in 131072+3 cycles from start, with no pix_valid gaps; without the macro, 131072+2*8192+1 cycles.

Source files
------------

// File: rtl/hack_screen_reader.sv
// Hack screen scan-out: fetches screen RAM words and serialises them LSB-first as a pixel stream.
// Define SCREEN_READER_PREFETCH_EN to prefetch the next word into a holding register for gapless output.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for start, no outputs active
// S_FETCH | read strobe for the current word address
// S_LOAD  | RAM data returns, captured into the shift register
// S_SHIFT | presenting pixels, shifting on each transfer
module hack_screen_reader #(
    parameter int WORDS_PER_ROW = 32,
    parameter int ROWS          = 256,
    parameter int ADDR_W        = 13
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic              pix,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy
);

    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_ROW * ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [15:0]       shreg_q, shreg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_bit;
    logic              last_word;

`ifdef SCREEN_READER_PREFETCH_EN
    logic [15:0] hold_q, hold_d;
    logic        pf_issued_q, pf_issued_d;
    logic        pf_cap_q, pf_cap_d;
`endif

    assign last_bit  = (cnt_q == 4'd15);
    assign last_word = (addr_q == LAST_WORD);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            col_q       <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
`ifdef SCREEN_READER_PREFETCH_EN
            hold_q      <= '0;
            pf_issued_q <= 1'b0;
            pf_cap_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
`ifdef SCREEN_READER_PREFETCH_EN
            hold_q      <= hold_d;
            pf_issued_q <= pf_issued_d;
            pf_cap_q    <= pf_cap_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        col_d     = col_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        mem_rd    = 1'b0;
        mem_addr  = addr_q;
        pix       = 1'b0;
        pix_valid = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        busy      = (state_q != S_IDLE);
`ifdef SCREEN_READER_PREFETCH_EN
        hold_d      = hold_q;
        pf_issued_d = pf_issued_q;
        pf_cap_d    = 1'b0;
        if (pf_cap_q) begin
            hold_d = mem_data;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = mem_data;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                pix_valid = 1'b1;
                pix       = shreg_q[0];
                line_end  = last_bit && (col_q == LAST_COL);
                frame_end = last_bit && last_word;
`ifdef SCREEN_READER_PREFETCH_EN
                // One read per word, issued on its first pixel; stalls must not re-issue.
                if ((cnt_q == 4'd0) && !last_word && !pf_issued_q) begin
                    mem_rd      = 1'b1;
                    mem_addr    = addr_q + 1'b1;
                    pf_issued_d = 1'b1;
                    pf_cap_d    = 1'b1;
                end
`endif
                if (pix_ready) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        if (last_word) begin
                            state_d = S_IDLE;
                            addr_d  = '0;
                            col_d   = '0;
                        end else begin
                            addr_d = addr_q + 1'b1;
                            col_d  = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
`ifdef SCREEN_READER_PREFETCH_EN
                            shreg_d     = hold_q;
                            cnt_d       = '0;
                            pf_issued_d = 1'b0;
`else
                            state_d = S_FETCH;
`endif
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hack_screen_reader.sv
// Scoreboard bench for hack_screen_reader on a reduced 32x16-word screen.
// Honours SCREEN_READER_PREFETCH_EN for the expected busy-cycle count.
module tb_hack_screen_reader;

    localparam int WPR  = 32;
    localparam int ROWS = 16;
    localparam int AW   = 13;
    localparam int NW   = WPR * ROWS;
    localparam int NPX  = NW * 16;
`ifdef SCREEN_READER_PREFETCH_EN
    localparam int BUSY_CYC = NPX + 2;
`else
    localparam int BUSY_CYC = NPX + 2 * NW;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [15:0]   mem_data = 16'h0;
    logic          pix, pix_valid, line_end, frame_end, busy;

    hack_screen_reader #(.WORDS_PER_ROW(WPR), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .line_end(line_end), .frame_end(frame_end), .busy(busy)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [NW];

    // Registered RAM; garbage on non-read cycles exposes mistimed captures.
    always @(posedge CLK) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        else        mem_data <= 16'($urandom);
    end

    int         compared = 0;
    int         mismatched = 0;
    logic [2:0] exp_q[$];
    int         exp_addr, n_xfer, n_le, n_fe, n_busy;
    logic       finished;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame();
        exp_q.delete();
        for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < 16; b++) begin
                exp_q.push_back({mem[w][b],
                                 (b == 15) && ((w % WPR) == WPR - 1),
                                 (b == 15) && (w == NW - 1)});
            end
        end
    endtask

    // rmode 0: ready always high; 1: random ready. abort_at>0 resets after that many transfers.
    task automatic run_frame(input int rmode, input bit hold_start, input int abort_at);
        logic       stalled;
        logic [3:0] prev;
        logic [2:0] e;
        bit         done;
        push_frame();
        exp_addr = 0; n_xfer = 0; n_le = 0; n_fe = 0; n_busy = 0;
        finished = 1'b0; stalled = 1'b0; prev = '0; done = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        pix_ready = (rmode == 0);
        @(negedge CLK);
        if (!hold_start) start = 1'b0;
        for (int cyc = 0; cyc < 4 * NPX + 4 * NW && !done; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (busy) n_busy++;
            if (cyc == 0) check("lat_fetch", {mem_rd, pix_valid, busy}, 3'b101);
            if (cyc == 1) check("lat_load", {mem_rd, pix_valid, busy}, 3'b001);
            if (cyc == 2) check("lat_first_px", pix_valid, 1'b1);
            if (mem_rd) begin
                check("rd_addr", mem_addr, exp_addr);
                exp_addr++;
            end
            if (stalled) check("stall_hold", {pix, pix_valid, line_end, frame_end}, prev);
            if (rmode == 1) pix_ready = 1'($urandom_range(0, 1));
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {pix, line_end, frame_end}, e);
                end
                n_xfer++;
                if (n_xfer == WPR * 16 && mem[WPR-1] == 16'h8000)
                    check("row0_last_px", {pix, line_end}, 2'b11);
                n_le += int'(line_end);
                n_fe += int'(frame_end);
                if (frame_end) begin
                    finished = 1'b1;
                    done = 1'b1;
                end
            end
            stalled = pix_valid && !pix_ready;
            prev = {pix, pix_valid, line_end, frame_end};
            if (abort_at > 0 && n_xfer == abort_at) begin
                RST_N = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) check("timeout", 1'b0, 1'b1);
        if (abort_at > 0) begin
            @(negedge CLK);
            check("abort_idle", {pix_valid, busy, mem_rd}, 3'b000);
            RST_N = 1'b1;
            exp_q.delete();
        end else if (finished) begin
            @(negedge CLK);
            check("busy_fall", busy, 1'b0);
            start = 1'b0;
            check("queue_empty", exp_q.size(), 0);
            @(negedge CLK);
            check("no_restart", busy, 1'b0);
        end
        pix_ready = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < NW; w++) mem[w] = 16'($urandom);
        mem[0] = 16'h0001;
        mem[WPR-1] = 16'h8000;

        RST_N = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_outs", {mem_addr, mem_rd, pix, pix_valid, line_end, frame_end, busy}, '0);
        end
        RST_N = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("idle_after_reset", {busy, mem_rd, pix_valid}, 3'b000);
        end

        // Word 0 / word 31 patterns under random backpressure
        run_frame(1, 1'b0, 0);
        check("f1_xfers", n_xfer, NPX);
        check("f1_line_ends", n_le, ROWS);

        // All-black frame at full rate, start held across the final transfer
        for (int w = 0; w < NW; w++) mem[w] = 16'hFFFF;
        run_frame(0, 1'b1, 0);
        check("f2_xfers", n_xfer, NPX);
        check("f2_line_ends", n_le, ROWS);
        check("f2_frame_ends", n_fe, 1);
        check("f2_busy_cycles", n_busy, BUSY_CYC);
        check("f2_reads", exp_addr, NW);

        // Abort mid-row 10, then rescan from address 0
        for (int w = 0; w < NW; w++) mem[w] = 16'($urandom);
        run_frame(0, 1'b0, 10 * WPR * 16 + 37);
        repeat (2) @(negedge CLK);
        run_frame(0, 1'b0, 0);
        check("f4_xfers", n_xfer, NPX);
        check("f4_frame_ends", n_fe, 1);
        check("f4_busy_cycles", n_busy, BUSY_CYC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
